// File: rtl/axis_pkt_arbiter.sv
// ============================================================================
// Module   : axis_pkt_arbiter
// Brief    : Packet-atomic round-robin merge of NUM_SRC AXI-Stream sources
//            with runaway-packet truncation at MAX_PKT_BEATS.
//            Optional per-source packet counters: define AXIS_ARB_PKT_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_pkt_arbiter #(
    parameter  int NUM_SRC       = 3,
    parameter  int DATA_W        = 64,
    parameter  int MAX_PKT_BEATS = 1024,
    localparam int SRC_W         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
`ifdef AXIS_ARB_PKT_COUNT_EN
    input  logic                            clear_counters,
    output logic [NUM_SRC-1:0][31:0]        pkt_count,
`endif
    input  logic [NUM_SRC-1:0]              src_ena,
    input  logic [NUM_SRC-1:0][DATA_W-1:0]  in_tdata,
    input  logic [NUM_SRC-1:0]              in_tvalid,
    input  logic [NUM_SRC-1:0]              in_tlast,
    output logic [NUM_SRC-1:0]              in_tready,
    output logic [DATA_W-1:0]               out_tdata,
    output logic                            out_tvalid,
    output logic                            out_tlast,
    input  logic                            out_tready,
    output logic [SRC_W-1:0]                grant_id,
    output logic                            busy,
    output logic                            trunc_pulse
);

    localparam int               CNT_W     = $clog2(MAX_PKT_BEATS) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_PKT_BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]   grant_q, grant_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               trunc_q, trunc_d;

    logic [NUM_SRC-1:0]   w_req;
    logic [2*NUM_SRC-1:0] w_req_dbl;
    logic [NUM_SRC-1:0]   w_req_rot;
    logic [SRC_W-1:0]     w_start;
    logic [SRC_W-1:0]     w_off;
    logic [SRC_W:0]       w_sum;
    logic [SRC_W-1:0]     w_grant;
    logic                 w_found;
    logic                 w_at_max;

    // Rotate requests so bit 0 is the source just after the last winner;
    // the lowest set bit of the rotated vector is the round-robin choice.
    always_comb begin
        w_req     = in_tvalid & src_ena;
        w_start   = (rr_ptr_q == SRC_W'(NUM_SRC - 1)) ? '0 : rr_ptr_q + SRC_W'(1);
        w_req_dbl = {w_req, w_req} >> w_start;
        w_req_rot = w_req_dbl[NUM_SRC-1:0];
        w_off     = '0;
        w_found   = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_off   = SRC_W'(i);
                w_found = 1'b1;
            end
        end
        w_sum = {1'b0, w_start} + {1'b0, w_off};
        if (w_sum >= (SRC_W + 1)'(NUM_SRC)) begin
            w_grant = SRC_W'(w_sum - (SRC_W + 1)'(NUM_SRC));
        end else begin
            w_grant = w_sum[SRC_W-1:0];
        end
    end

    assign w_at_max = (beat_cnt_q == LAST_BEAT);

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        trunc_d    = 1'b0;
        in_tready  = '0;
        out_tdata  = '0;
        out_tvalid = 1'b0;
        out_tlast  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    grant_d    = w_grant;
                    rr_ptr_d   = w_grant;
                    beat_cnt_d = '0;
                    state_d    = ST_PASS;
                end
            end
            ST_PASS: begin
                out_tdata           = in_tdata[grant_q];
                out_tvalid          = in_tvalid[grant_q];
                out_tlast           = in_tlast[grant_q] | w_at_max;
                in_tready[grant_q]  = out_tready;
                if (in_tvalid[grant_q] && out_tready) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    // A genuine tlast on the limit beat is a normal end, not a truncation.
                    if (in_tlast[grant_q]) begin
                        state_d = ST_IDLE;
                    end else if (w_at_max) begin
                        state_d = ST_DRAIN;
                        trunc_d = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                in_tready[grant_q] = 1'b1;
                if (in_tvalid[grant_q] && in_tlast[grant_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= SRC_W'(NUM_SRC - 1);
            grant_q    <= '0;
            beat_cnt_q <= '0;
            trunc_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
            trunc_q    <= trunc_d;
        end
    end

    assign grant_id    = grant_q;
    assign busy        = (state_q != ST_IDLE);
    assign trunc_pulse = trunc_q;

`ifdef AXIS_ARB_PKT_COUNT_EN
    logic w_pkt_end;

    // Forced tlast also ends the packet as seen downstream, so it counts here.
    assign w_pkt_end = (state_q == ST_PASS) && out_tvalid && out_tready && out_tlast;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_pkt_cnt
        logic [31:0] cnt_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else if (clear_counters) begin
                cnt_q <= '0;
            end else if (w_pkt_end && (grant_q == SRC_W'(gi)) && (cnt_q != 32'hFFFF_FFFF)) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
        assign pkt_count[gi] = cnt_q;
    end
`endif

endmodule

`default_nettype wire
